// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and helpers for the oversampling UART receiver
package uart_pkg;

  localparam int OS_DEFAULT = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  // Out-of-range word lengths fall back to the common 8-bit frame.
  function automatic logic [3:0] clamp_bits(input logic [3:0] bits, input int max_bits);
    return (bits >= 4'd5 && int'(bits) <= max_bits) ? bits : 4'd8;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-stage input synchroniser, resets to the idle-high line level
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver, runtime 5..9 data bits, parity, 1/2 stop
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_W      = 9,
  parameter int OS          = OS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              os_tick,
  input  logic [3:0]        cfg_data_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              busy
);

  localparam int CW = $clog2(OS);
  localparam logic [CW-1:0] C_LO   = CW'(OS / 2 - 1);
  localparam logic [CW-1:0] C_MID  = CW'(OS / 2);
  localparam logic [CW-1:0] C_VOTE = CW'(OS / 2 + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OS - 1);

  logic                   rxs;
  logic [SYNC_STAGES-1:0] settle;
  rx_state_e              state;
  logic [CW-1:0]          cnt;
  logic [1:0]             smp;
  logic [3:0]             bit_idx, nbits_l;
  parity_e                par_l;
  logic                   stop2_l, stop_idx, armed, par_bad, frm_bad, zero_run;
  logic [DATA_W-1:0]      shreg;
  logic                   vote, at_vote, at_end, last_stop, frame_now, brk_now;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rxs));

  assign vote      = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign at_vote   = (cnt == C_VOTE);
  assign at_end    = (cnt == C_LAST);
  assign last_stop = !stop2_l || stop_idx;
  assign frame_now = frm_bad | ~vote;
  // Break covers everything up to and including the first stop bit.
  assign brk_now   = stop_idx ? zero_run : (zero_run & ~vote);

  // The synchroniser's reset preset would look like an idle line; arming waits until real data has flushed through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) settle <= '0;
    else        settle <= (settle << 1) | SYNC_STAGES'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      smp        <= '0;
      bit_idx    <= '0;
      nbits_l    <= 4'd8;
      par_l      <= PAR_NONE;
      stop2_l    <= 1'b0;
      stop_idx   <= 1'b0;
      armed      <= 1'b0;
      par_bad    <= 1'b0;
      frm_bad    <= 1'b0;
      zero_run   <= 1'b0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (os_tick) begin
        if (state != IDLE && state != BRK_WAIT) cnt <= cnt + 1'b1;
        if (cnt == C_LO)  smp[0] <= rxs;
        if (cnt == C_MID) smp[1] <= rxs;
        case (state)
          IDLE: begin
            if (rxs && settle[SYNC_STAGES-1]) begin
              armed <= 1'b1;
            end else if (!rxs && armed) begin
              state    <= START;
              busy     <= 1'b1;
              cnt      <= '0;
              nbits_l  <= clamp_bits(cfg_data_bits, DATA_W);
              par_l    <= (cfg_parity == 2'd3) ? PAR_NONE : parity_e'(cfg_parity);
              stop2_l  <= cfg_stop2;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              shreg    <= '0;
              par_bad  <= 1'b0;
              frm_bad  <= 1'b0;
              zero_run <= 1'b1;
            end
          end
          START: begin
            if (at_vote && vote) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (at_end) begin
              state <= DATA;
            end
          end
          DATA: begin
            if (at_vote) begin
              shreg    <= shreg | (DATA_W'(vote) << bit_idx);
              zero_run <= zero_run & ~vote;
            end
            if (at_end) begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx == nbits_l - 4'd1) state <= (par_l == PAR_NONE) ? STOP : PARITY;
            end
          end
          PARITY: begin
            if (at_vote) begin
              zero_run <= zero_run & ~vote;
              par_bad  <= (vote != ((par_l == PAR_ODD) ? ~^shreg : ^shreg));
            end
            if (at_end) state <= STOP;
          end
          STOP: begin
            if (at_vote) begin
              if (!stop_idx) zero_run <= zero_run & ~vote;
              frm_bad <= frame_now;
              if (last_stop) begin
                rx_data    <= shreg;
                parity_err <= par_bad;
                frame_err  <= frame_now | brk_now;
                break_det  <= brk_now;
                rx_valid   <= 1'b1;
                state      <= brk_now ? BRK_WAIT : IDLE;
                busy       <= brk_now;
              end
            end else if (at_end) begin
              stop_idx <= 1'b1;
            end
          end
          BRK_WAIT: begin
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - randomized and directed frames checked against a frame-level model
module tb_uart_rx_os;

  localparam int OS = 16;
  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          os_tick = 1'b0;
  logic [3:0]    cfg_data_bits = 4'd8;
  logic [1:0]    cfg_parity = 2'd0;
  logic          cfg_stop2 = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid, parity_err, frame_err, break_det, busy;

  int n_checks = 0;
  int n_errors = 0;
  bit hold_high = 1'b0;
  int div_cnt = 0;
  int wide_cnt = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bd;
  } ev_t;

  ev_t evq[$];

  uart_rx_os #(.DATA_W(DW), .OS(OS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .os_tick(os_tick),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .break_det(break_det), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    os_tick = hold_high || (div_cnt == 0);
    div_cnt = (div_cnt + 1) % 4;
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      evq.push_back('{rx_data, parity_err, frame_err, break_det});
      if (prev_valid) wide_cnt++;
    end
    prev_valid = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input bit v, input bit spike);
    for (int t = 0; t < OS; t++) begin
      rx = (spike && t == OS / 2) ? ~v : v;
      tick_wait(1);
    end
  endtask

  function automatic int eff_bits(input int nbr);
    return (nbr >= 5 && nbr <= 9) ? nbr : 8;
  endfunction

  function automatic bit good_parity(input int nbr, input int par, input int data);
    int n;
    n = eff_bits(nbr);
    return (($countones(data & ((1 << n) - 1)) % 2) == 1) ^ (par == 2);
  endfunction

  function automatic ev_t model(input int nbr, input int par, input bit st2, input int data,
                                input bit pflip, input bit s1l, input bit s2l);
    ev_t e;
    int  d;
    bit  pen, sent, brk;
    d    = data & ((1 << eff_bits(nbr)) - 1);
    pen  = (par == 1 || par == 2);
    sent = good_parity(nbr, par, data) ^ pflip;
    brk  = (d == 0) && (!pen || !sent) && s1l;
    e.d  = 9'(d);
    e.pe = pen && pflip;
    e.fe = s1l || (st2 && s2l) || brk;
    e.bd = brk;
    return e;
  endfunction

  task automatic send_frame(input int nbr, input int par, input bit st2, input int data,
                            input bit pflip, input bit s1l, input bit s2l, input bit spike,
                            input int gap);
    cfg_data_bits = 4'(nbr);
    cfg_parity    = 2'(par);
    cfg_stop2     = st2;
    send_bit(1'b0, spike);
    cfg_data_bits = 4'($urandom);
    cfg_parity    = 2'($urandom);
    cfg_stop2     = 1'($urandom);
    for (int i = 0; i < eff_bits(nbr); i++) send_bit(data[i], spike);
    if (par == 1 || par == 2) send_bit(good_parity(nbr, par, data) ^ pflip, spike);
    send_bit(~s1l, spike);
    if (st2) send_bit(~s2l, spike);
    rx = 1'b1;
    tick_wait(gap);
  endtask

  task automatic expect_ev(input string tag, input ev_t e);
    int  waited;
    ev_t g;
    waited = 0;
    while (evq.size() == 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    chk({tag, "_valid"}, 32'(evq.size() > 0), 32'd1);
    if (evq.size() > 0) begin
      g = evq.pop_front();
      chk({tag, "_data"}, 32'(g.d), 32'(e.d));
      chk({tag, "_perr"}, 32'(g.pe), 32'(e.pe));
      chk({tag, "_ferr"}, 32'(g.fe), 32'(e.fe));
      chk({tag, "_brk"}, 32'(g.bd), 32'(e.bd));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({rx_valid, rx_data, parity_err, frame_err, break_det, busy}), 32'd0);
    rst_n = 1'b1;
    tick_wait(4);

    send_frame(8, 0, 0, 'hA5, 0, 0, 0, 0, 4);
    expect_ev("8n1_a5", model(8, 0, 0, 'hA5, 0, 0, 0));
    tick_wait(8);
    chk("hold_data", 32'(rx_data), 32'h0A5);

    send_frame(7, 1, 0, 'h35, 0, 0, 0, 0, 4);
    expect_ev("7e1_ok", model(7, 1, 0, 'h35, 0, 0, 0));
    send_frame(7, 1, 0, 'h35, 1, 0, 0, 0, 4);
    expect_ev("7e1_bad", model(7, 1, 0, 'h35, 1, 0, 0));

    send_frame(9, 2, 1, 'h1C3, 0, 0, 1, 0, OS + 8);
    expect_ev("9o2_stop", model(9, 2, 1, 'h1C3, 0, 0, 1));

    send_frame(8, 0, 0, 'h5A, 0, 0, 0, 1, 4);
    expect_ev("noise_5a", model(8, 0, 0, 'h5A, 0, 0, 0));

    for (int k = 0; k < 20; k++) begin
      int nbr, par, data;
      bit st2, pf, s1, s2, quiet;
      nbr   = $urandom_range(0, 15);
      par   = $urandom_range(0, 3);
      data  = $urandom_range(0, 511);
      st2   = 1'($urandom);
      pf    = ($urandom_range(0, 3) == 0);
      s1    = ($urandom_range(0, 5) == 0);
      s2    = st2 && ($urandom_range(0, 5) == 0);
      quiet = st2 ? s2 : s1;
      send_frame(nbr, par, st2, data, pf, s1, s2, 0, quiet ? OS + 8 : $urandom_range(0, 6));
      expect_ev($sformatf("rnd%0d", k), model(nbr, par, st2, data, pf, s1, s2));
    end

    cfg_data_bits = 4'd8;
    cfg_parity    = 2'd0;
    cfg_stop2     = 1'b0;
    rx = 1'b0;
    tick_wait(3 * 10 * OS);
    chk("brk_busy_hold", 32'(busy), 32'd1);
    rx = 1'b1;
    tick_wait(2);
    chk("brk_busy_drop", 32'(busy), 32'd0);
    tick_wait(OS);
    expect_ev("break", model(8, 0, 0, 0, 0, 1, 0));
    chk("brk_single", 32'(evq.size()), 32'd0);

    rx = 1'b0;
    tick_wait(2);
    chk("glitch_busy", 32'(busy), 32'd1);
    tick_wait(2);
    rx = 1'b1;
    tick_wait(OS);
    chk("glitch_idle", 32'(busy), 32'd0);
    chk("glitch_noframe", 32'(evq.size()), 32'd0);

    hold_high = 1'b1;
    tick_wait(8);
    send_frame(8, 0, 0, 'h00, 0, 0, 0, 0, 0);
    send_frame(8, 0, 0, 'hFF, 0, 0, 0, 0, 8);
    expect_ev("b2b_00", model(8, 0, 0, 'h00, 0, 0, 0));
    expect_ev("b2b_ff", model(8, 0, 0, 'hFF, 0, 0, 0));
    chk("pulse_width", 32'(wide_cnt), 32'd0);
    hold_high = 1'b0;
    tick_wait(8);

    cfg_data_bits = 4'd8;
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    rst_n = 1'b0;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mid", 32'({rx_valid, rx_data, parity_err, frame_err, break_det, busy}), 32'd0);
    rst_n = 1'b1;
    tick_wait(4);
    chk("reset_low_noarm", 32'(busy), 32'd0);
    rx = 1'b1;
    tick_wait(4);
    chk("reset_noframe", 32'(evq.size()), 32'd0);
    send_frame(6, 2, 0, 'h2B, 0, 0, 0, 0, 4);
    expect_ev("after_reset", model(6, 2, 0, 'h2B, 0, 0, 0));

    tick_wait(OS);
    chk("final_width", 32'(wide_cnt), 32'd0);
    chk("final_stray", 32'(evq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
